// File: rtl/cpu_decode_queue.sv
// cpu_decode_queue: bit-granular variable-length instruction decoder fed through a code bit buffer.
// Latency 1 cycle from sufficient buffered bits to out_valid; sustains one instruction per cycle.
// Backpressure: in_ready drops when a beat would overflow the buffer; out_* hold while out_valid&!out_ready.
// Optional macro CPU_DECODE_ILLEGAL_EN: unknown opcodes raise sticky illegal and stall decode.
module cpu_decode_queue #(
    parameter int OPSZ    = 5,
    parameter int RGSZ    = 3,
    parameter int IMSZ    = 16,
    parameter int FETCH_W = 16,
    parameter int BUF_W   = 64,
    parameter int PC_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FETCH_W-1:0] in_data,
    input  logic               flush,
    input  logic [PC_W-1:0]    flush_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OPSZ-1:0]    out_opcode,
    output logic [RGSZ-1:0]    out_regop1,
    output logic [RGSZ-1:0]    out_regop2,
    output logic [IMSZ-1:0]    out_immop1,
    output logic [PC_W-1:0]    out_pc,
    output logic [7:0]         out_len,
    output logic               illegal
);
    localparam int LW = $clog2(BUF_W + 1);

    localparam logic [OPSZ-1:0] OP_OUT = OPSZ'(0);
    localparam logic [OPSZ-1:0] OP_IMP = OPSZ'(1);
    localparam logic [OPSZ-1:0] OP_ILT = OPSZ'(2);
    localparam logic [OPSZ-1:0] OP_IEQ = OPSZ'(3);
    localparam logic [OPSZ-1:0] OP_IGT = OPSZ'(4);
    localparam logic [OPSZ-1:0] OP_INC = OPSZ'(5);
    localparam logic [OPSZ-1:0] OP_DEC = OPSZ'(6);
    localparam logic [OPSZ-1:0] OP_ADD = OPSZ'(7);
    localparam logic [OPSZ-1:0] OP_SUB = OPSZ'(8);
    localparam logic [OPSZ-1:0] OP_MUL = OPSZ'(9);
    localparam logic [OPSZ-1:0] OP_DIV = OPSZ'(10);
    localparam logic [OPSZ-1:0] OP_AND = OPSZ'(11);
    localparam logic [OPSZ-1:0] OP_OR  = OPSZ'(12);
    localparam logic [OPSZ-1:0] OP_XOR = OPSZ'(13);
    localparam logic [OPSZ-1:0] OP_IMM = OPSZ'(14);
    localparam logic [OPSZ-1:0] OP_JMP = OPSZ'(15);
    localparam logic [OPSZ-1:0] OP_JLT = OPSZ'(16);
    localparam logic [OPSZ-1:0] OP_JEQ = OPSZ'(17);
    localparam logic [OPSZ-1:0] OP_JGT = OPSZ'(18);

    localparam logic [LW-1:0] LEN_OP = LW'(OPSZ);
    localparam logic [LW-1:0] LEN_R1 = LW'(OPSZ + RGSZ);
    localparam logic [LW-1:0] LEN_R2 = LW'(OPSZ + 2 * RGSZ);
    localparam logic [LW-1:0] LEN_RI = LW'(OPSZ + RGSZ + IMSZ);
    localparam logic [LW-1:0] LEN_J  = LW'(OPSZ + IMSZ);

    // Bits at and above lvl_q are kept zero so appends can simply OR in.
    logic [BUF_W-1:0] buf_q;
    logic [LW-1:0]    lvl_q;
    logic [PC_W-1:0]  pc_q;

    logic [OPSZ-1:0]  head;
    logic [LW-1:0]    dlen;
    logic [RGSZ-1:0]  d_r1, d_r2;
    logic [IMSZ-1:0]  d_imm;
    logic             has_op, can_dec, load, push;
    logic [LW-1:0]    lvl_shift, lvl_d;
    logic [BUF_W-1:0] buf_shift, buf_d;
    logic [LW:0]      lvl_room;
`ifdef CPU_DECODE_ILLEGAL_EN
    logic             unknown;
    logic             illegal_q;
`endif

    always_comb begin
        head  = buf_q[OPSZ-1:0];
        dlen  = LEN_OP;
        d_r1  = '0;
        d_r2  = '0;
        d_imm = '0;
`ifdef CPU_DECODE_ILLEGAL_EN
        unknown = 1'b0;
`endif
        case (head)
            OP_OUT, OP_IMP, OP_ILT, OP_IEQ, OP_IGT, OP_INC, OP_DEC: begin
                dlen = LEN_R1;
                d_r1 = buf_q[OPSZ +: RGSZ];
            end
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_XOR: begin
                dlen = LEN_R2;
                d_r1 = buf_q[OPSZ +: RGSZ];
                d_r2 = buf_q[OPSZ+RGSZ +: RGSZ];
            end
            OP_IMM: begin
                dlen  = LEN_RI;
                d_r1  = buf_q[OPSZ +: RGSZ];
                d_imm = buf_q[OPSZ+RGSZ +: IMSZ];
            end
            OP_JMP, OP_JLT, OP_JEQ, OP_JGT: begin
                dlen  = LEN_J;
                d_imm = buf_q[OPSZ +: IMSZ];
            end
            default: begin
`ifdef CPU_DECODE_ILLEGAL_EN
                unknown = 1'b1;
`endif
            end
        endcase
    end

    assign has_op = (lvl_q >= LEN_OP);
`ifdef CPU_DECODE_ILLEGAL_EN
    assign can_dec = has_op && (lvl_q >= dlen) && !unknown && !illegal_q;
    assign illegal = illegal_q;
`else
    assign can_dec = has_op && (lvl_q >= dlen);
    assign illegal = 1'b0;
`endif
    assign load     = can_dec && (!out_valid || out_ready);
    assign lvl_room = {1'b0, lvl_q} + (LW+1)'(FETCH_W);
    assign in_ready = !flush && (lvl_room <= (LW+1)'(BUF_W));
    assign push     = in_valid && in_ready;

    // Pop first, then append at the post-pop level: same result as appending at L then shifting.
    always_comb begin
        lvl_shift = load ? (lvl_q - dlen) : lvl_q;
        buf_shift = load ? (buf_q >> dlen) : buf_q;
        lvl_d     = lvl_shift;
        buf_d     = buf_shift;
        if (push) begin
            lvl_d = lvl_shift + LW'(FETCH_W);
            buf_d = buf_shift | (BUF_W'(in_data) << lvl_shift);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q      <= '0;
            lvl_q      <= '0;
            pc_q       <= '0;
            out_valid  <= 1'b0;
            out_opcode <= '0;
            out_regop1 <= '0;
            out_regop2 <= '0;
            out_immop1 <= '0;
            out_pc     <= '0;
            out_len    <= '0;
`ifdef CPU_DECODE_ILLEGAL_EN
            illegal_q  <= 1'b0;
`endif
        end else if (flush) begin
            buf_q      <= '0;
            lvl_q      <= '0;
            pc_q       <= flush_pc;
            out_valid  <= 1'b0;
            out_opcode <= '0;
            out_regop1 <= '0;
            out_regop2 <= '0;
            out_immop1 <= '0;
            out_pc     <= '0;
            out_len    <= '0;
`ifdef CPU_DECODE_ILLEGAL_EN
            illegal_q  <= 1'b0;
`endif
        end else begin
            buf_q <= buf_d;
            lvl_q <= lvl_d;
            if (load) begin
                out_valid  <= 1'b1;
                out_opcode <= head;
                out_regop1 <= d_r1;
                out_regop2 <= d_r2;
                out_immop1 <= d_imm;
                out_pc     <= pc_q;
                out_len    <= 8'(dlen);
                pc_q       <= pc_q + PC_W'(dlen);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
`ifdef CPU_DECODE_ILLEGAL_EN
            // Beats are still accepted while stalled; only the head is frozen.
            if (has_op && unknown) begin
                illegal_q <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_cpu_decode_queue.sv
// Directed bench for cpu_decode_queue at default parameters; honours CPU_DECODE_ILLEGAL_EN.
module tb_cpu_decode_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        flush = 1'b0;
    logic [15:0] flush_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_opcode;
    logic [2:0]  out_regop1, out_regop2;
    logic [15:0] out_immop1;
    logic [15:0] out_pc;
    logic [7:0]  out_len;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    cpu_decode_queue dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .flush(flush), .flush_pc(flush_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_regop1(out_regop1), .out_regop2(out_regop2),
        .out_immop1(out_immop1), .out_pc(out_pc), .out_len(out_len),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush(input logic [15:0] pc);
        in_valid = 1'b0;
        flush    = 1'b1;
        flush_pc = pc;
        tick();
        flush    = 1'b0;
    endtask

    task automatic push_beat(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({out_valid, out_opcode, out_regop1, out_regop2, out_immop1, out_pc, out_len, illegal} !== 58'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%0b op=%0h pc=%0h len=%0d ill=%0b required all zero",
                     out_valid, out_opcode, out_pc, out_len, illegal);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b required 1", in_ready);
        end
    endtask

    task automatic test_basic_add;
        do_flush(16'h0000);
        out_ready = 1'b0;
        push_beat(16'h0227);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_latency: got out_valid=%0b required 0", out_valid);
        end
        tick();
        checks++;
        if ({out_valid, out_opcode, out_regop1, out_regop2, out_immop1, out_pc, out_len} !==
            {1'b1, 5'd7, 3'd1, 3'd2, 16'h0000, 16'h0000, 8'd11}) begin
            errors++;
            $display("FAIL add_decode: got v=%0b op=%0d r1=%0d r2=%0d imm=%0h pc=%0h len=%0d required 1 7 1 2 0 0 11",
                     out_valid, out_opcode, out_regop1, out_regop2, out_immop1, out_pc, out_len);
        end
        tick();
        checks++;
        if ({out_valid, out_opcode, out_pc, out_len} !== {1'b1, 5'd7, 16'h0000, 8'd11}) begin
            errors++;
            $display("FAIL add_hold: got v=%0b op=%0d pc=%0h len=%0d required 1 7 0 11",
                     out_valid, out_opcode, out_pc, out_len);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_drain: got out_valid=%0b required 0 (5 bits left)", out_valid);
        end
    endtask

    task automatic test_straddle;
        do_flush(16'h0000);
        out_ready = 1'b0;
        push_beat(16'hEF6E);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL imm_partial: got out_valid=%0b required 0", out_valid);
        end
        push_beat(16'h00BE);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL imm_latency: got out_valid=%0b required 0", out_valid);
        end
        tick();
        checks++;
        if ({out_valid, out_opcode, out_regop1, out_regop2, out_immop1, out_pc, out_len} !==
            {1'b1, 5'd14, 3'd3, 3'd0, 16'hBEEF, 16'h0000, 8'd24}) begin
            errors++;
            $display("FAIL imm_decode: got v=%0b op=%0d r1=%0d r2=%0d imm=%0h pc=%0h len=%0d required 1 14 3 0 beef 0 24",
                     out_valid, out_opcode, out_regop1, out_regop2, out_immop1, out_pc, out_len);
        end
    endtask

    function automatic logic [15:0] inc_beat(input int k);
        logic [2:0] ra, rb;
        ra = 3'((2 * k) % 8);
        rb = 3'((2 * k + 1) % 8);
        return {rb, 5'd5, ra, 5'd5};
    endfunction

    task automatic test_backpressure;
        int  bi = 0;
        int  ri = 0;
        logic seen_low = 1'b0;
        logic hs_in;
        do_flush(16'h0000);
        for (int cyc = 0; cyc < 300 && ri < 16; cyc++) begin
            out_ready = (cyc >= 12);
            in_valid  = (bi < 8);
            in_data   = inc_beat(bi);
            #1;
            if (cyc >= 2 && cyc < 12) begin
                checks++;
                if ({out_valid, out_opcode, out_regop1, out_pc} !== {1'b1, 5'd5, 3'd0, 16'h0000}) begin
                    errors++;
                    $display("FAIL bp_stable cyc %0d: got v=%0b op=%0d r1=%0d pc=%0h required 1 5 0 0",
                             cyc, out_valid, out_opcode, out_regop1, out_pc);
                end
            end
            if (!in_ready) seen_low = 1'b1;
            hs_in = in_valid && in_ready;
            if (out_valid && out_ready) begin
                checks++;
                if ({out_opcode, out_regop1, out_pc, out_len} !== {5'd5, 3'(ri % 8), 16'(ri * 8), 8'd8}) begin
                    errors++;
                    $display("FAIL bp_order #%0d: got op=%0d r1=%0d pc=%0h len=%0d required 5 %0d %0h 8",
                             ri, out_opcode, out_regop1, out_pc, out_len, ri % 8, ri * 8);
                end
                ri++;
            end
            tick();
            if (hs_in) bi++;
            if (cyc == 11) begin
                checks++;
                if (bi != 4 || in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_fill: got beats=%0d in_ready=%0b required 4 0", bi, in_ready);
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (ri != 16 || !seen_low) begin
            errors++;
            $display("FAIL bp_drain: got insts=%0d ready_low=%0b required 16 1", ri, seen_low);
        end
    endtask

    task automatic test_flush;
        do_flush(16'h0000);
        out_ready = 1'b0;
        push_beat(16'h0227);
        tick();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre: got out_valid=%0b required 1", out_valid);
        end
        flush    = 1'b1;
        flush_pc = 16'h0100;
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_ready: got %0b required 0", in_ready);
        end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear: got out_valid=%0b required 0", out_valid);
        end
        push_beat(16'h0227);
        tick();
        checks++;
        if ({out_valid, out_opcode, out_pc} !== {1'b1, 5'd7, 16'h0100}) begin
            errors++;
            $display("FAIL flush_pc: got v=%0b op=%0d pc=%0h required 1 7 100", out_valid, out_opcode, out_pc);
        end
    endtask

    task automatic test_back_to_back;
        logic [47:0] v;
        v = 48'(5) | (48'(15) << 8) | (48'(16'h0040) << 13) | (48'(8'h25) << 29);
        do_flush(16'h0000);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = v[15:0];
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: got out_valid=%0b required 0", out_valid);
        end
        in_data = v[31:16];
        tick();
        checks++;
        if ({out_valid, out_opcode, out_regop1, out_pc, out_len} !== {1'b1, 5'd5, 3'd0, 16'd0, 8'd8}) begin
            errors++;
            $display("FAIL b2b_inc0: got v=%0b op=%0d r1=%0d pc=%0d len=%0d required 1 5 0 0 8",
                     out_valid, out_opcode, out_regop1, out_pc, out_len);
        end
        in_data = v[47:32];
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_opcode, out_regop1, out_immop1, out_pc, out_len} !==
            {1'b1, 5'd15, 3'd0, 16'h0040, 16'd8, 8'd21}) begin
            errors++;
            $display("FAIL b2b_jmp: got v=%0b op=%0d r1=%0d imm=%0h pc=%0d len=%0d required 1 15 0 40 8 21",
                     out_valid, out_opcode, out_regop1, out_immop1, out_pc, out_len);
        end
        tick();
        checks++;
        if ({out_valid, out_opcode, out_regop1, out_immop1, out_pc} !== {1'b1, 5'd5, 3'd1, 16'h0000, 16'd29}) begin
            errors++;
            $display("FAIL b2b_inc1: got v=%0b op=%0d r1=%0d imm=%0h pc=%0d required 1 5 1 0 29",
                     out_valid, out_opcode, out_regop1, out_immop1, out_pc);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_unknown_opcode;
        do_flush(16'h0000);
        out_ready = 1'b0;
        push_beat(16'hFFFF);
        tick();
`ifdef CPU_DECODE_ILLEGAL_EN
        checks++;
        if ({illegal, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL illegal_set: got ill=%0b v=%0b required 1 0", illegal, out_valid);
        end
        repeat (3) tick();
        checks++;
        if ({illegal, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL illegal_stall: got ill=%0b v=%0b required 1 0", illegal, out_valid);
        end
        do_flush(16'h0000);
        checks++;
        if ({illegal, out_valid} !== 2'b00) begin
            errors++;
            $display("FAIL illegal_flush: got ill=%0b v=%0b required 0 0", illegal, out_valid);
        end
`else
        checks++;
        if ({out_valid, out_opcode, out_regop1, out_regop2, out_immop1, out_len, illegal} !==
            {1'b1, 5'd31, 3'd0, 3'd0, 16'h0000, 8'd5, 1'b0}) begin
            errors++;
            $display("FAIL unknown_decode: got v=%0b op=%0d r1=%0d r2=%0d imm=%0h len=%0d ill=%0b required 1 31 0 0 0 5 0",
                     out_valid, out_opcode, out_regop1, out_regop2, out_immop1, out_len, illegal);
        end
`endif
    endtask

    task automatic test_reset_midinst;
        do_flush(16'h0000);
        out_ready = 1'b0;
        push_beat(16'hEF6E);
        rst = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_valid: got %0b required 0", out_valid);
        end
        rst = 1'b0;
        tick();
        push_beat(16'h0227);
        tick();
        checks++;
        if ({out_valid, out_opcode, out_regop1, out_pc} !== {1'b1, 5'd7, 3'd1, 16'h0000}) begin
            errors++;
            $display("FAIL rst_mid_next: got v=%0b op=%0d r1=%0d pc=%0h required 1 7 1 0",
                     out_valid, out_opcode, out_regop1, out_pc);
        end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_straddle();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_unknown_opcode();
        test_reset_midinst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
